// File: rtl/acc_pkg.sv
// Shared definitions for the operand stream accumulator: FSM state encoding
// and the default operand / counter widths.
package acc_pkg;

  localparam int unsigned DefaultN    = 32;
  localparam int unsigned DefaultCntW = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/acc_adder.sv
// N-bit ripple-carry adder built from per-bit full-adder cells.
// Ports:
//   a, b  - addends
//   sum   - a + b modulo 2^N
//   cout  - carry out of bit N-1
module acc_adder
  import acc_pkg::*;
#(
  parameter int unsigned N = DefaultN
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_fa
    logic p;
    assign p          = a[i] ^ b[i];
    assign sum[i]     = p ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (p & carry[i]);
  end

  assign cout = carry[N];

endmodule

// File: rtl/operand_stream_accumulator.sv
// Accumulates a burst of operand beats (valid/ready in, closed by in_last) and
// presents the sum, a sticky carry-out flag and a saturating beat count on a
// valid/ready result port.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last - operand beat stream
//   out_valid/out_ready            - result handshake
//   out_sum                        - burst sum modulo 2^N
//   out_overflow                   - any carry out of bit N-1 during the burst
//   out_count                      - beats in the burst, saturating at 2^CNT_W-1
module operand_stream_accumulator
  import acc_pkg::*;
#(
  parameter int unsigned N     = DefaultN,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_overflow,
  output logic [CNT_W-1:0] out_count
);

  acc_state_e state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;

  logic [N-1:0] add_sum;
  logic         add_cout;
  logic         accept;

  acc_adder #(
    .N (N)
  ) u_adder (
    .a    (acc_q),
    .b    (in_data),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign in_ready = (state_q != StHold);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // First beat overwrites whatever the previous burst left behind.
          acc_d       = in_data;
          ovf_d       = 1'b0;
          cnt_d       = CNT_W'(1);
          state_d     = in_last ? StHold : StAccum;
          out_valid_d = in_last;
        end
      end
      StAccum: begin
        if (accept) begin
          acc_d       = add_sum;
          ovf_d       = ovf_q | add_cout;
          cnt_d       = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          state_d     = in_last ? StHold : StAccum;
          out_valid_d = in_last;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_sum      = acc_q;
  assign out_overflow = ovf_q;
  assign out_count    = cnt_q;

endmodule

// File: tb/tb_operand_stream_accumulator.sv
module tb_operand_stream_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_overflow;
  logic [7:0]  out_count;

  int tests_run    = 0;
  int tests_failed = 0;

  operand_stream_accumulator #(
    .N     (32),
    .CNT_W (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow),
    .out_count    (out_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [31:0] data, input logic last);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    step();
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    in_last  = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sum", out_sum, 32'd0);
    check("rst_ovf", 32'(out_overflow), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    rst = 1'b0;
    step();

    // Burst 3,4,5 -> 12
    beat(32'd3, 1'b0);
    check("b1_no_valid_mid", 32'(out_valid), 32'd0);
    beat(32'd4, 1'b0);
    beat(32'd5, 1'b1);
    idle_in();
    check("b1_valid", 32'(out_valid), 32'd1);
    check("b1_sum", out_sum, 32'd12);
    check("b1_count", 32'(out_count), 32'd3);
    check("b1_ovf", 32'(out_overflow), 32'd0);
    check("b1_in_ready_hold", 32'(in_ready), 32'd0);
    step();
    check("b1_release_valid", 32'(out_valid), 32'd0);
    check("b1_release_ready", 32'(in_ready), 32'd1);

    // Overflow: 0xFFFFFFFF + 2
    beat(32'hFFFF_FFFF, 1'b0);
    beat(32'h0000_0002, 1'b1);
    idle_in();
    check("ovf_valid", 32'(out_valid), 32'd1);
    check("ovf_sum", out_sum, 32'h0000_0001);
    check("ovf_flag", 32'(out_overflow), 32'd1);
    check("ovf_count", 32'(out_count), 32'd2);
    step();

    // Single beat with backpressure; junk offered while held is ignored
    out_ready = 1'b0;
    beat(32'h0000_00A5, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    in_last  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_sum", out_sum, 32'h0000_00A5);
      check("bp_count", 32'(out_count), 32'd1);
      check("bp_ovf", 32'(out_overflow), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    idle_in();
    out_ready = 1'b1;
    check("bp_still_valid", 32'(out_valid), 32'd1);
    step();
    check("bp_released", 32'(out_valid), 32'd0);

    // 300 beats of 1 -> count saturates at 255
    for (int i = 0; i < 300; i++) begin
      beat(32'd1, (i == 299));
    end
    idle_in();
    check("sat_valid", 32'(out_valid), 32'd1);
    check("sat_sum", out_sum, 32'd300);
    check("sat_count", 32'(out_count), 32'd255);
    check("sat_ovf", 32'(out_overflow), 32'd0);
    step();

    // Reset aborts a partial burst
    beat(32'd7, 1'b0);
    beat(32'd9, 1'b0);
    idle_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_sum", out_sum, 32'd0);
    check("abort_count", 32'(out_count), 32'd0);
    step();
    check("abort_no_late_valid", 32'(out_valid), 32'd0);
    beat(32'd2, 1'b1);
    idle_in();
    check("post_abort_valid", 32'(out_valid), 32'd1);
    check("post_abort_sum", out_sum, 32'd2);
    check("post_abort_count", 32'(out_count), 32'd1);

    // Reset wins over a pending result and an offered beat
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd5;
    in_last  = 1'b1;
    step();
    rst = 1'b0;
    idle_in();
    check("rst_prio_valid", 32'(out_valid), 32'd0);
    check("rst_prio_sum", out_sum, 32'd0);
    check("rst_prio_count", 32'(out_count), 32'd0);
    check("rst_prio_ready", 32'(in_ready), 32'd1);

    // Burst 1,1 with idle gaps
    beat(32'd1, 1'b0);
    idle_in();
    in_data = 32'd99;
    step();
    check("gap_sum1", out_sum, 32'd1);
    check("gap_count1", 32'(out_count), 32'd1);
    check("gap_valid1", 32'(out_valid), 32'd0);
    step();
    check("gap_sum2", out_sum, 32'd1);
    check("gap_count2", 32'(out_count), 32'd1);
    beat(32'd1, 1'b1);
    idle_in();
    check("gap_valid", 32'(out_valid), 32'd1);
    check("gap_sum", out_sum, 32'd2);
    check("gap_count", 32'(out_count), 32'd2);
    check("gap_ovf", 32'(out_overflow), 32'd0);
    step();
    check("gap_release", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/operand_stream_accumulator.md
OPERAND_STREAM_ACCUMULATOR -- requirements
Module: operand_stream_accumulator

Interface
REQ-001 SHALL have parameter N, default 32, giving the width of operands and of the running sum.
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of the beat counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: an operand beat is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-007 SHALL have port in_data, input, N bits: operand to add.
REQ-008 SHALL have port in_last, input, 1 bit: the offered beat closes the current burst.
REQ-009 SHALL have port out_valid, output, 1 bit: the burst result is presented.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream takes the result.
REQ-011 SHALL have port out_sum, output, N bits: burst sum modulo 2^N.
REQ-012 SHALL have port out_overflow, output, 1 bit: at least one carry out of bit N-1 occurred during the burst.
REQ-013 SHALL have port out_count, output, CNT_W bits: number of beats in the burst, saturating.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, ACCUM and HOLD.
REQ-015 SHALL treat a beat as accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-016 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in HOLD.
REQ-017 On a beat accepted in IDLE, SHALL load acc=in_data, overflow=0 and count=1, ignoring stale contents.
REQ-018 On a beat accepted in ACCUM, SHALL update acc=acc+in_data (low N bits), set overflow sticky when the N-bit add carries out, and increment count, saturating at 2^CNT_W-1.
REQ-019 SHALL move IDLE->ACCUM on an accepted beat with in_last=0.
REQ-020 SHALL move IDLE or ACCUM ->HOLD on an accepted beat with in_last=1, after including that beat in acc, overflow and count.
REQ-021 SHALL assert out_valid exactly in HOLD, so out_valid rises the cycle after the last beat is accepted (latency 1).
REQ-022 SHALL keep out_sum, out_overflow and out_count equal to acc, overflow and count, held stable for the whole time out_valid=1.
REQ-023 SHALL, on out_valid=1 and out_ready=1, return to IDLE the next cycle; no beat is accepted in that cycle.
REQ-024 SHALL hold state and registers while in_valid=0, in IDLE or ACCUM.
REQ-025 SHALL accept a single-beat burst (in_last=1 in IDLE), giving count=1, sum=in_data and overflow=0.
REQ-026 SHALL ignore in_data and in_last in any cycle where no beat is accepted.

Reset
REQ-027 While rst=1 at a clock edge, SHALL enter IDLE and clear acc, overflow and count to 0.
REQ-028 Following a reset edge, SHALL present out_valid=0, in_ready=1, out_sum=0, out_overflow=0 and out_count=0.
REQ-029 Reset during ACCUM or HOLD SHALL discard the partial or pending result; no out_valid follows for that burst.
REQ-030 Reset SHALL take priority over any handshake in the same cycle.

Structure
REQ-031 SHALL take the state enum (IDLE/ACCUM/HOLD) and the default N and CNT_W from shared package acc_pkg.
REQ-032 SHALL perform the N-bit add with carry-out in one sub-module, acc_adder (inputs a, b; outputs sum[N-1:0] and cout), as a ripple of per-bit full-adder cells.
REQ-033 SHALL register all outputs except in_ready, which is decoded from state.

Verification
REQ-034 Burst 3, 4, 5 (last on 5), out_ready=1 -> one cycle after the last beat, out_valid=1 with sum=12, count=3, overflow=0; IDLE on the next cycle.
REQ-035 Burst 0xFFFFFFFF, 0x00000002 (last) -> sum=0x00000001, overflow=1, count=2.
REQ-036 Single beat 0xA5 with in_last=1, out_ready held 0 for 4 cycles -> out_valid stays 1 and outputs stay stable while in_ready=0; releases one cycle after out_ready=1.
REQ-037 300 beats of value 1 (last on the final beat) -> sum=300, count=255 (saturated), overflow=0.
REQ-038 Burst 7, 9, then rst=1 for one cycle, then burst 2 (last) -> sum=2, count=1; no result emitted for the aborted burst.
REQ-039 Burst 1, 1 with in_valid gaps (valid 1,0,0,1 with last on the second beat) -> sum=2, count=2; idle cycles leave acc unchanged.
